// File: rtl/sys_defs.sv
// Shared core types: physical/architectural register encodings and the
// branch-stack checkpoint entry used by the rename recovery path.
package sys_defs;

  localparam int PHYS_REG_W = 6;

  typedef logic [PHYS_REG_W-1:0] PHYS_REG;
  typedef logic [4:0]            ARCH_REG;

  typedef struct packed {
    PHYS_REG pr;
    logic    ready;
  } PHYS_WITH_READY;

  localparam ARCH_REG ZERO_REG = 5'd31;

  localparam int BS_DEPTH = 4;
  localparam int BS_TAG_W = $clog2(BS_DEPTH);

  typedef logic [BS_TAG_W-1:0] BS_TAG;

  typedef struct packed {
    logic                  valid;
    logic                  resolved;
    PHYS_WITH_READY [30:0] map;
  } BS_ENTRY;

endpackage

// File: rtl/bs_cdb_fwd.sv
// Applies the two CDB completion ports to one 31-entry rename map,
// marking every field whose physical register just completed as ready.
module bs_cdb_fwd
  import sys_defs::*;
(
  input  PHYS_WITH_READY [30:0] map_in,
  input  logic [1:0]            cdb_rd_en,
  input  PHYS_REG [1:0]         cdb_rd,
  output PHYS_WITH_READY [30:0] map_out
);

  always_comb begin
    map_out = map_in;
    for (int j = 0; j < 31; j++) begin
      for (int k = 0; k < 2; k++) begin
        if (cdb_rd_en[k] && (map_in[j].pr == cdb_rd[k])) begin
          map_out[j].ready = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/branch_stack.sv
// Rename-map checkpoint stack: snapshots the map per dispatched branch,
// keeps ready bits current from the CDB, and rolls back on mispredict.
module branch_stack
  import sys_defs::*;
#(
  parameter int BS_DEPTH = sys_defs::BS_DEPTH,
  parameter int BS_TAG_W = $clog2(BS_DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 dis_br_valid,
  input  PHYS_WITH_READY [1:0][30:0] dis_slot_map,
  input  logic [1:0]                 cdb_rd_en,
  input  PHYS_REG [1:0]              cdb_rd,
  input  logic                       ex_br_valid,
  input  logic [BS_TAG_W-1:0]        ex_br_tag,
  input  logic                       ex_br_mispred,
  output logic [1:0][BS_TAG_W-1:0]   bs_tag,
  output logic [1:0]                 bs_nFree,
  output logic                       br_pred_wrong,
  output PHYS_WITH_READY [30:0]      bs_recov_map,
  output logic [BS_DEPTH-1:0]        bs_squash_mask
);

  localparam int CNT_W = BS_TAG_W + 1;

  typedef logic [BS_TAG_W-1:0] tag_t;
  typedef logic [CNT_W-1:0]    cnt_t;

  BS_ENTRY                    entries [BS_DEPTH];
  tag_t                       head;
  tag_t                       tail;
  cnt_t                       count;

  PHYS_WITH_READY [30:0]      stored_fwd [BS_DEPTH];
  PHYS_WITH_READY [1:0][30:0] dis_fwd;

  tag_t                       head_p1;
  tag_t                       tail_p1;
  tag_t                       head_next;
  tag_t                       dist_tag;
  cnt_t                       free_cnt;
  logic                       ret0;
  logic                       ret1;
  logic [1:0]                 n_ret;
  logic [1:0]                 alloc_en;
  logic [1:0]                 n_alloc;

  for (genvar g = 0; g < BS_DEPTH; g++) begin : g_entry_fwd
    bs_cdb_fwd u_entry_fwd (
      .map_in    (entries[g].map),
      .cdb_rd_en (cdb_rd_en),
      .cdb_rd    (cdb_rd),
      .map_out   (stored_fwd[g])
    );
  end

  for (genvar d = 0; d < 2; d++) begin : g_dis_fwd
    bs_cdb_fwd u_dis_fwd (
      .map_in    (dis_slot_map[d]),
      .cdb_rd_en (cdb_rd_en),
      .cdb_rd    (cdb_rd),
      .map_out   (dis_fwd[d])
    );
  end

  bs_cdb_fwd u_recov_fwd (
    .map_in    (entries[ex_br_tag].map),
    .cdb_rd_en (cdb_rd_en),
    .cdb_rd    (cdb_rd),
    .map_out   (bs_recov_map)
  );

  assign br_pred_wrong = ex_br_valid & ex_br_mispred;

  assign head_p1   = head + 1'b1;
  assign tail_p1   = tail + 1'b1;
  assign bs_tag[0] = tail;
  assign bs_tag[1] = dis_br_valid[0] ? tail_p1 : tail;

  assign free_cnt = cnt_t'(BS_DEPTH) - count;
  assign bs_nFree = (free_cnt >= cnt_t'(2)) ? 2'd2 : free_cnt[1:0];

  // Retire only looks at resolved bits already latched, never this cycle's resolve.
  assign ret0      = entries[head].valid & entries[head].resolved;
  assign ret1      = ret0 & entries[head_p1].valid & entries[head_p1].resolved;
  assign n_ret     = {1'b0, ret0} + {1'b0, ret1};
  assign head_next = head + tag_t'(n_ret);

  assign alloc_en = dis_br_valid & {2{~br_pred_wrong}};
  assign n_alloc  = {1'b0, alloc_en[0]} + {1'b0, alloc_en[1]};

  // Age is measured from head so a completely full stack still squashes correctly.
  assign dist_tag = ex_br_tag - head;

  always_comb begin
    tag_t dist_i;
    bs_squash_mask = '0;
    for (int i = 0; i < BS_DEPTH; i++) begin
      dist_i = tag_t'(i) - head;
      bs_squash_mask[i] = br_pred_wrong && (dist_i >= dist_tag) &&
                          ({1'b0, dist_i} < count);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < BS_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BS_DEPTH; i++) begin
        entries[i].map <= stored_fwd[i];
      end
      if (ex_br_valid && !ex_br_mispred) begin
        entries[ex_br_tag].resolved <= 1'b1;
      end
      if (ret0) begin
        entries[head].valid    <= 1'b0;
        entries[head].resolved <= 1'b0;
      end
      if (ret1) begin
        entries[head_p1].valid    <= 1'b0;
        entries[head_p1].resolved <= 1'b0;
      end
      for (int i = 0; i < BS_DEPTH; i++) begin
        if (bs_squash_mask[i]) begin
          entries[i].valid    <= 1'b0;
          entries[i].resolved <= 1'b0;
        end
      end
      if (alloc_en[0]) begin
        entries[bs_tag[0]] <= '{valid: 1'b1, resolved: 1'b0, map: dis_fwd[0]};
      end
      if (alloc_en[1]) begin
        entries[bs_tag[1]] <= '{valid: 1'b1, resolved: 1'b0, map: dis_fwd[1]};
      end

      head <= head_next;
      if (br_pred_wrong) begin
        tail  <= ex_br_tag;
        count <= {1'b0, tag_t'(ex_br_tag - head_next)};
      end else begin
        tail  <= tail + tag_t'(n_alloc);
        count <= count - cnt_t'(n_ret) + cnt_t'(n_alloc);
      end
    end
  end

endmodule

// File: tb/tb_branch_stack.sv
// Directed self-checking bench for branch_stack: allocation, CDB ready
// tracking, mispredict rollback, out-of-order resolve/retire and wrap-around.
module tb_branch_stack;
  import sys_defs::*;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [1:0]                 dis_br_valid;
  PHYS_WITH_READY [1:0][30:0] dis_slot_map;
  logic [1:0]                 cdb_rd_en;
  PHYS_REG [1:0]              cdb_rd;
  logic                       ex_br_valid;
  logic [1:0]                 ex_br_tag;
  logic                       ex_br_mispred;
  logic [1:0][1:0]            bs_tag;
  logic [1:0]                 bs_nFree;
  logic                       br_pred_wrong;
  PHYS_WITH_READY [30:0]      bs_recov_map;
  logic [3:0]                 bs_squash_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_stack #(.BS_DEPTH(4), .BS_TAG_W(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .dis_br_valid   (dis_br_valid),
    .dis_slot_map   (dis_slot_map),
    .cdb_rd_en      (cdb_rd_en),
    .cdb_rd         (cdb_rd),
    .ex_br_valid    (ex_br_valid),
    .ex_br_tag      (ex_br_tag),
    .ex_br_mispred  (ex_br_mispred),
    .bs_tag         (bs_tag),
    .bs_nFree       (bs_nFree),
    .br_pred_wrong  (br_pred_wrong),
    .bs_recov_map   (bs_recov_map),
    .bs_squash_mask (bs_squash_mask)
  );

  // Map field j holds physical register (base + j) mod 64, all with the same ready bit.
  function automatic PHYS_WITH_READY [30:0] make_map(input int base, input logic rdy);
    PHYS_WITH_READY [30:0] m;
    for (int j = 0; j < 31; j++) begin
      m[j].pr    = PHYS_REG'(base + j);
      m[j].ready = rdy;
    end
    return m;
  endfunction

  function automatic logic [63:0] pr_rdy(input int pr, input logic rdy);
    return {57'b0, PHYS_REG'(pr), rdy};
  endfunction

  function automatic logic [63:0] recov_field(input int j);
    return {57'b0, bs_recov_map[j].pr, bs_recov_map[j].ready};
  endfunction

  task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Drives one cycle's inputs after the falling edge; outputs settle before the rising edge.
  task automatic apply_stimulus(input logic [1:0] br_v,
                                input PHYS_WITH_READY [30:0] m0,
                                input PHYS_WITH_READY [30:0] m1,
                                input logic [1:0] c_en, input int c0, input int c1,
                                input logic ex_v, input int ex_t, input logic ex_m);
    @(negedge clk);
    dis_br_valid    = br_v;
    dis_slot_map[0] = m0;
    dis_slot_map[1] = m1;
    cdb_rd_en       = c_en;
    cdb_rd[0]       = PHYS_REG'(c0);
    cdb_rd[1]       = PHYS_REG'(c1);
    ex_br_valid     = ex_v;
    ex_br_tag       = 2'(ex_t);
    ex_br_mispred   = ex_m;
    #1;
  endtask

  task automatic idle();
    apply_stimulus(2'b00, '0, '0, 2'b00, 0, 0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    PHYS_WITH_READY [30:0] map_a, map_b, map_c, map_d, map_e, map_f;
    map_a = make_map(32, 1'b0);
    map_b = make_map(40, 1'b0);
    map_c = make_map(8, 1'b1);
    map_d = make_map(16, 1'b1);
    map_e = make_map(48, 1'b1);
    map_f = make_map(24, 1'b1);

    reset         = 1'b1;
    dis_br_valid  = '0;
    dis_slot_map  = '0;
    cdb_rd_en     = '0;
    cdb_rd        = '0;
    ex_br_valid   = 1'b0;
    ex_br_tag     = '0;
    ex_br_mispred = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    idle();
    check_output("reset_nfree", 64'(bs_nFree), 64'd2);
    check_output("reset_pw", 64'(br_pred_wrong), 64'd0);
    check_output("reset_mask", 64'(bs_squash_mask), 64'b0000);
    check_output("reset_tags", 64'(bs_tag), 64'(4'b0000));

    // Dual dispatch; CDB port 1 completes reg 34 during allocation of map A.
    apply_stimulus(2'b11, map_a, map_b, 2'b10, 0, 34, 1'b0, 0, 1'b0);
    check_output("dual_tags", 64'(bs_tag), 64'(4'b01_00));

    idle();
    check_output("after_dual_nfree", 64'(bs_nFree), 64'd2);
    check_output("after_dual_tail", 64'(bs_tag[0]), 64'd2);
    check_output("slot1_idle_tag", 64'(bs_tag[1]), 64'd2);

    apply_stimulus(2'b00, '0, '0, 2'b01, 33, 0, 1'b0, 0, 1'b0);

    apply_stimulus(2'b11, map_c, map_d, 2'b00, 0, 0, 1'b0, 0, 1'b0);
    check_output("second_dual_tags", 64'(bs_tag), 64'(4'b11_10));
    check_output("second_dual_nfree", 64'(bs_nFree), 64'd2);

    idle();
    check_output("full_nfree", 64'(bs_nFree), 64'd0);

    apply_stimulus(2'b00, '0, '0, 2'b01, 40, 0, 1'b1, 1, 1'b1);
    check_output("misp1_pw", 64'(br_pred_wrong), 64'd1);
    check_output("misp1_mask", 64'(bs_squash_mask), 64'b1110);
    check_output("misp1_recov0", recov_field(0), pr_rdy(40, 1'b1));
    check_output("misp1_recov1", recov_field(1), pr_rdy(41, 1'b0));

    apply_stimulus(2'b01, map_e, '0, 2'b00, 0, 0, 1'b0, 0, 1'b0);
    check_output("post_misp1_tail", 64'(bs_tag[0]), 64'd1);
    check_output("post_misp1_nfree", 64'(bs_nFree), 64'd2);

    apply_stimulus(2'b01, map_f, '0, 2'b00, 0, 0, 1'b0, 0, 1'b0);
    check_output("single_tag2", 64'(bs_tag[0]), 64'd2);

    idle();
    check_output("count3_nfree", 64'(bs_nFree), 64'd1);

    apply_stimulus(2'b00, '0, '0, 2'b00, 0, 0, 1'b1, 0, 1'b1);
    check_output("misp0_pw", 64'(br_pred_wrong), 64'd1);
    check_output("misp0_mask", 64'(bs_squash_mask), 64'b0111);
    check_output("misp0_recov0", recov_field(0), pr_rdy(32, 1'b0));
    check_output("misp0_recov_cdb33", recov_field(1), pr_rdy(33, 1'b1));
    check_output("misp0_recov_dis34", recov_field(2), pr_rdy(34, 1'b1));
    check_output("misp0_recov3", recov_field(3), pr_rdy(35, 1'b0));

    idle();
    check_output("empty_nfree", 64'(bs_nFree), 64'd2);
    check_output("empty_tags", 64'(bs_tag), 64'(4'b00_00));
    check_output("empty_pw", 64'(br_pred_wrong), 64'd0);
    check_output("empty_mask", 64'(bs_squash_mask), 64'b0000);

    apply_stimulus(2'b11, map_c, map_d, 2'b00, 0, 0, 1'b0, 0, 1'b0);
    check_output("refill_tags01", 64'(bs_tag), 64'(4'b01_00));
    apply_stimulus(2'b11, map_e, map_f, 2'b00, 0, 0, 1'b0, 0, 1'b0);
    check_output("refill_tags23", 64'(bs_tag), 64'(4'b11_10));

    apply_stimulus(2'b00, '0, '0, 2'b00, 0, 0, 1'b1, 1, 1'b0);
    check_output("resolve1_nfree", 64'(bs_nFree), 64'd0);
    check_output("resolve1_pw", 64'(br_pred_wrong), 64'd0);
    check_output("resolve1_mask", 64'(bs_squash_mask), 64'b0000);

    apply_stimulus(2'b00, '0, '0, 2'b00, 0, 0, 1'b1, 0, 1'b0);
    check_output("resolve0_nfree", 64'(bs_nFree), 64'd0);

    idle();
    check_output("pre_retire_nfree", 64'(bs_nFree), 64'd0);

    idle();
    check_output("post_retire_nfree", 64'(bs_nFree), 64'd2);
    check_output("post_retire_tail", 64'(bs_tag[0]), 64'd0);

    apply_stimulus(2'b00, '0, '0, 2'b00, 0, 0, 1'b1, 2, 1'b0);
    idle();

    apply_stimulus(2'b01, map_a, '0, 2'b00, 0, 0, 1'b0, 0, 1'b0);
    check_output("wrap_alloc_tag", 64'(bs_tag[0]), 64'd0);
    check_output("wrap_alloc_nfree", 64'(bs_nFree), 64'd2);

    apply_stimulus(2'b00, '0, '0, 2'b00, 0, 0, 1'b1, 3, 1'b1);
    check_output("wrap_misp_mask", 64'(bs_squash_mask), 64'b1001);
    check_output("wrap_misp_recov0", recov_field(0), pr_rdy(24, 1'b1));
    check_output("wrap_misp_recov5", recov_field(5), pr_rdy(29, 1'b1));

    apply_stimulus(2'b01, map_c, '0, 2'b00, 0, 0, 1'b0, 0, 1'b0);
    check_output("wrap_redispatch_tag", 64'(bs_tag[0]), 64'd3);
    check_output("wrap_redispatch_nfree", 64'(bs_nFree), 64'd2);

    idle();
    check_output("wrap_tail_rollover", 64'(bs_tag[0]), 64'd0);
    check_output("wrap_final_nfree", 64'(bs_nFree), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_stack.md
Name: branch_stack

Overview:
- Checkpoint controller for the rename map table in the 2-way R10K core.
- On each dispatched branch, it stores a snapshot of the 31-entry map: value, physical register and ready bit.
- While a checkpoint is live, CDB completions update its ready bits.
- On a branch mispredict, it supplies the recovery map to the map table and rolls back its own younger checkpoints. Occupancy is reported to the hazard unit so dispatch stalls on a full stack.

Parameters:
- BS_DEPTH, 4: number of checkpoint entries; must be a power of 2 and at least 2.
- BS_TAG_W, $clog2(BS_DEPTH): width of a checkpoint tag.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- dis_br_valid  in  2  slot i dispatches a branch this cycle; slot 1 is only valid together with slot 0 dispatching
- dis_slot_map  in  2x31 PHYS_WITH_READY  map state after slot i's rename, including slot i's destination write
- cdb_rd_en  in  2  CDB broadcast valid
- cdb_rd  in  2 PHYS_REG  CDB completed physical registers
- ex_br_valid  in  1  a branch resolves this cycle (at most one per cycle)
- ex_br_tag  in  BS_TAG_W  checkpoint tag of the resolving branch
- ex_br_mispred  in  1  the resolving branch was mispredicted
- bs_tag  out  2 x BS_TAG_W  tag assigned to each slot's branch this cycle (combinational)
- bs_nFree  out  2  min(2, free entries), for the hazard unit
- br_pred_wrong  out  1  ex_br_valid & ex_br_mispred (combinational)
- bs_recov_map  out  31 PHYS_WITH_READY  recovery map (combinational)
- bs_squash_mask  out  BS_DEPTH  entries squashed by a mispredict this cycle

Behaviour:
- Storage: circular buffer with head (oldest), tail (next free) and count in 0..BS_DEPTH. Each entry holds valid, resolved and a map of 31 entries.
- Reset: head=tail=count=0; all entries have valid=0 and resolved=0.
- Reset-time outputs: bs_nFree=2 (with BS_DEPTH>=2), br_pred_wrong=0, bs_squash_mask=0.
- Allocation:
  - bs_tag[0]=tail. bs_tag[1]=tail+1 if slot 0 is also a branch, else tail.
  - Allocated entries are written at the clock edge with dis_slot_map[i], valid=1, resolved=0. tail and count advance by the number of branches.
  - Dispatching more branches than bs_nFree is a protocol violation and is not handled.
- CDB update, every cycle:
  - For every valid stored entry and every k with cdb_rd_en[k], any map field whose register equals cdb_rd[k] gets ready=1.
  - CDB also applies to the maps being allocated in the same cycle: if cdb_rd[k] matches, the ready bit is written as 1.
- Correct resolve (ex_br_valid & !ex_br_mispred): set resolved on entry ex_br_tag.
- Retire: each cycle, at most 2 consecutive resolved entries at head are freed. Freeing clears valid, advances head and decrements count.
  - Retire sees resolved bits set in earlier cycles only, so an entry retires at the earliest one cycle after it resolves.
- Mispredict (ex_br_valid & ex_br_mispred), same cycle:
  - br_pred_wrong=1.
  - bs_recov_map is entry ex_br_tag's map, with the current cycle's CDB matches forced to ready=1.
  - bs_squash_mask has a 1 for the mispredicted entry and for every valid entry younger than it, from tag to tail-1, wrapping.
  - Next state: tail=ex_br_tag and all squashed entries become invalid. count is recomputed as (tail-head) mod BS_DEPTH, or BS_DEPTH if full with no squash (not possible here). Any retire in the same cycle is applied first.
  - Dispatch allocation in a mispredict cycle is suppressed.
- Wrap-around: head and tail wrap modulo BS_DEPTH, and the full condition is distinguished by count.
- Mispredict on an invalid tag: protocol violation, not handled.
- When br_pred_wrong=0, bs_recov_map is don't-care but driven deterministically from entry ex_br_tag.

Decomposition:
- Shared package (sys_defs):
  - existing: PHYS_REG, ARCH_REG, PHYS_WITH_READY, ZERO_REG
  - new: BS_DEPTH constant, BS_TAG typedef, BS_ENTRY struct {valid, resolved, PHYS_WITH_READY[30:0] map}
- Sub-module bs_cdb_fwd: purely combinational; applies the 2-port CDB ready update to one 31-entry map. It is instanced per stored entry, per incoming dispatch map, and on the recovery output.

Test Plan:
- Reset, no activity: bs_nFree=2, br_pred_wrong=0, bs_squash_mask=4'b0000.
- Dual branch dispatch with slot maps A and B: bs_tag = {1,0}. Next cycle count=2 and bs_nFree=2. Dispatch two more: bs_nFree=0.
- Entry 0 holds map reg 33 with ready=0. Apply cdb_rd_en=2'b01, cdb_rd[0]=33 → stored ready becomes 1. A later mispredict on tag 0 returns bs_recov_map with ready=1 for that register.
- 4 entries live. Mispredict tag 1 with a simultaneous CDB on reg 40 → br_pred_wrong=1, bs_squash_mask=4'b1110, reg 40 ready in recov map. Next cycle tail=1 and count=1.
- Out-of-order correct resolve: resolve tag 1, then tag 0 → both retire in the same cycle after tag 0 resolves. head advances by 2 and bs_nFree returns to 2.
- Wrap: head=3, tail=1 (entries 3 and 0 live). Mispredict tag 3 → bs_squash_mask=4'b1001, next tail=3, count=0. Then a dispatch gets bs_tag[0]=3.
